mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbiter and access sequencer that shares the single-ported unified memory between instruction fetch and the load/store path of the multicycle MIPS datapath. It accepts requests from both requesters and grants one at a time. It drives the memory for a fixed number of wait cycles and returns read data with a one-cycle done pulse. It sits between the Control-driven datapath (fetch address from PC, MemRead/MemWrite from the control unit) and the memory array.

## Interface
- AW, 32, address width
- DW, 32, data width
- WAIT_CYC, 2, cycles mem_en is held per access (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address
- if_done  out  1  one-cycle pulse, fetch complete
- if_rdata  out  DW  fetched word, held until next fetch completes
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_done  out  1  one-cycle pulse, data access complete
- d_rdata  out  DW  loaded word, held until next load completes
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid during the last mem_en cycle
- busy  out  1  access in progress (ACCESS or RESP)
- owner  out  1  0 = fetch, 1 = data; valid while busy

## Operation
- FSM states:
  - IDLE: if any req, select winner; latch addr, wdata and we; set owner; go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: mem_en=1 for exactly WAIT_CYC cycles (down-counter loaded with WAIT_CYC-1). On the last cycle, capture mem_rdata into the winner's rdata register (loads and fetches only), then go to RESP.
  - RESP: pulse the winner's done; ignore all requests; go to IDLE.
- Selection (default): fixed priority, data over fetch.
- mem_we=1 only in ACCESS with owner=1 and latched we=1. mem_addr and mem_wdata come from the latched values and are stable for the whole access. They are 0 in IDLE.
- A store updates no rdata register; d_done still pulses.
- Requester protocol: req and its payload are stable from assertion until done is sampled high. Req is deasserted on that same edge. The arbiter does not sample payload after IDLE.
- A request raised while the arbiter is busy waits; it is arbitrated in the next IDLE cycle.
- Reset (any state): state=IDLE, counter=0, all outputs 0 (mem_en, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, busy, owner). An in-flight access is abandoned with no done pulse.

## Timing
- Request seen in IDLE at cycle t:
  - mem_en high cycles t+1 … t+WAIT_CYC
  - done high at cycle t+WAIT_CYC+1
  - rdata valid from cycle t+WAIT_CYC+1
  - IDLE again at cycle t+WAIT_CYC+2
- Throughput: one access per WAIT_CYC+2 cycles. Back-to-back requests leave one IDLE cycle between accesses.
- busy is high from t+1 through t+WAIT_CYC+1.
- done and rdata are registered outputs; no combinational path from req to any output.
- WAIT_CYC=1: ACCESS lasts a single cycle; latency is 2 cycles.

## Configuration
- ARB_RR_EN defined: round-robin on ties.
  - When both reqs are high in IDLE, grant goes to the requester not served last.
  - The last-served flag resets to fetch, so the first tie goes to data.
  - A single requester is always granted.
- ARB_RR_EN undefined: fixed data-over-fetch priority; no last-served state.

## Test plan
1. **Reset values:** hold reset 3 cycles with if_req=d_req=1 → all outputs 0, no mem_en. Release reset → fetch or data granted per policy at the first IDLE cycle.
2. **Single fetch (WAIT_CYC=2):** if_req with if_addr=0x00400000, mem_rdata=0x20080005 → mem_en and mem_addr=0x00400000 in cycles 1–2; if_done=1 in cycle 3 only; if_rdata=0x20080005; mem_we=0 throughout.
3. **Store:** d_req, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF → mem_we=1 in both ACCESS cycles with the given address and data; d_done pulses; d_rdata keeps its previous value.
4. **Tie:** if_req and d_req raised in the same cycle, both re-raised immediately after completion, three rounds.
   - Default build: data served every round; fetch never served.
   - ARB_RR_EN build: grants D, F, D, and owner matches each grant.
5. **Wait while busy:** if_req raised in the middle of a data ACCESS → no glitch on mem_addr; fetch granted in the IDLE cycle after d_done; if_done arrives WAIT_CYC+1 cycles later.
6. **Reset mid-ACCESS:** assert reset during cycle 1 of a load → mem_en=0, busy=0 next cycle; d_done never pulses; d_rdata=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and load/store.
// Define ARB_RR_EN for round-robin on ties; default build is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          grant_d;

`ifdef ARB_RR_EN
  // 1 = data was served last; a tie goes to whichever side was not.
  logic last_d;
  always_comb grant_d = d_req & (~if_req | ~last_d);
`else
  always_comb grant_d = d_req;
`endif

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would make later lines in
  // the block see this cycle's new state and change the timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      owner     <= 1'b0;
`ifdef ARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state     <= ACCESS;
            cnt       <= CW'(WAIT_CYC - 1);
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            owner     <= grant_d;
            mem_we    <= grant_d & d_we;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
`ifdef ARB_RR_EN
            last_d    <= grant_d;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            // Read data is only guaranteed on the last enabled cycle.
            if (owner) begin
              d_done <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks plus a scoreboard monitor
// that pairs each granted access and done pulse with the expected transaction.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WAIT_CYC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 32'hBAD0_BAD0;
  logic          busy;
  logic          owner;

  mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          sb[$];
  txn_t          mt;
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            n_checks = 0;
  int            n_fail = 0;
  int            en_run = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic          prev_done = 1'b0;

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a ^ 32'h5A5A_0000;
  endfunction

  task automatic push(input logic own, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd);
    txn_t t;
    t.owner = own;
    t.we    = we;
    t.addr  = a;
    t.wdata = wd;
    t.rdata = we ? '0 : mem_read(a);
    sb.push_back(t);
  endtask

  task automatic wait_done(input bit want_d, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (want_d ? d_done : if_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Memory model and scoreboard monitor; read data is valid only on the last enabled cycle.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      en_run       = 0;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
      prev_done    = 1'b0;
      sb.delete();
      mem_rdata    = 32'hBAD0_BAD0;
    end else begin
      if (mem_en && en_run == 0) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_grant: access to %h started with nothing expected", mem_addr);
        end else if ({owner, mem_we, mem_addr} !== {sb[0].owner, sb[0].we, sb[0].addr} ||
                     (sb[0].we && mem_wdata !== sb[0].wdata)) begin
          n_fail++;
          $display("FAIL mon_grant: got owner=%b we=%b addr=%h wdata=%h, expected owner=%b we=%b addr=%h wdata=%h",
                   owner, mem_we, mem_addr, mem_wdata, sb[0].owner, sb[0].we, sb[0].addr, sb[0].wdata);
        end
      end
      if (mem_en && en_run > 0) begin
        n_checks++;
        if (mem_addr !== last_addr) begin
          n_fail++;
          $display("FAIL mon_addr_stable: got %h expected %h", mem_addr, last_addr);
        end
      end
      if (!mem_en && en_run != 0) begin
        n_checks++;
        if (en_run != WAIT_CYC) begin
          n_fail++;
          $display("FAIL mon_en_len: mem_en held %0d cycles, expected %0d", en_run, WAIT_CYC);
        end
      end
      if (if_done || d_done) begin
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL mon_done_width: done high 2+ cycles (if_done=%b d_done=%b)", if_done, d_done);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_done_unexpected: if_done=%b d_done=%b with nothing expected", if_done, d_done);
        end else begin
          mt = sb.pop_front();
          if (mt.owner) begin
            if (!mt.we) exp_d_rdata = mt.rdata;
          end else begin
            exp_if_rdata = mt.rdata;
          end
          if ({if_done, d_done} !== {~mt.owner, mt.owner} || if_rdata !== exp_if_rdata ||
              d_rdata !== exp_d_rdata) begin
            n_fail++;
            $display("FAIL mon_done: got if_done=%b d_done=%b if_rdata=%h d_rdata=%h, expected %b %b %h %h",
                     if_done, d_done, if_rdata, d_rdata, ~mt.owner, mt.owner, exp_if_rdata, exp_d_rdata);
          end
        end
      end
      prev_done = if_done | d_done;
      en_run    = mem_en ? en_run + 1 : 0;
      last_addr = mem_addr;
      if (mem_en && mem_we && en_run == WAIT_CYC) mem[mem_addr] = mem_wdata;
      mem_rdata = (mem_en && en_run == WAIT_CYC) ? mem_read(mem_addr) : 32'hBAD0_BAD0;
    end
  end

  task automatic test_reset();
    int cyc;
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0040_0010; d_addr = 32'h1001_0040; d_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, busy, owner} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got en=%b we=%b addr=%h wd=%h ifd=%b dd=%b ifr=%h dr=%h busy=%b own=%b, expected all 0",
                 mem_en, mem_we, mem_addr, mem_wdata, if_done, d_done, if_rdata, d_rdata, busy, owner);
      end
    end
    reset = 1'b0;
    push(1'b1, 1'b0, d_addr, d_wdata);
    push(1'b0, 1'b0, if_addr, '0);
    @(negedge clk);
    n_checks++;
    if ({mem_en, busy, owner, mem_addr} !== {1'b1, 1'b1, 1'b1, 32'h1001_0040}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got en=%b busy=%b owner=%b addr=%h, expected 1 1 1 10010040",
               mem_en, busy, owner, mem_addr);
    end
    wait_done(1'b1, 4 * WAIT_CYC + 6, cyc);
    n_checks++;
    if (cyc != WAIT_CYC) begin
      n_fail++;
      $display("FAIL reset_d_latency: got %0d expected %0d", cyc, WAIT_CYC);
    end
    d_req = 1'b0;
    wait_done(1'b0, 4 * WAIT_CYC + 6, cyc);
    n_checks++;
    if (cyc != WAIT_CYC + 2) begin
      n_fail++;
      $display("FAIL reset_if_follow: got %0d expected %0d", cyc, WAIT_CYC + 2);
    end
    if_req = 1'b0;
  endtask

  task automatic test_single_fetch();
    logic en_x;
    mem[32'h0040_0000] = 32'h2008_0005;
    @(negedge clk);
    if_addr = 32'h0040_0000; if_req = 1'b1;
    push(1'b0, 1'b0, if_addr, '0);
    for (int k = 1; k <= WAIT_CYC + 2; k++) begin
      @(negedge clk);
      en_x = (k <= WAIT_CYC);
      n_checks++;
      if ({mem_en, mem_we, if_done, busy} !== {en_x, 1'b0, (k == WAIT_CYC + 1), (k <= WAIT_CYC + 1)}) begin
        n_fail++;
        $display("FAIL fetch_ctrl c%0d: got en=%b we=%b done=%b busy=%b, expected %b 0 %b %b",
                 k, mem_en, mem_we, if_done, busy, en_x, (k == WAIT_CYC + 1), (k <= WAIT_CYC + 1));
      end
      if (k != WAIT_CYC + 1) begin
        n_checks++;
        if (mem_addr !== (en_x ? 32'h0040_0000 : 32'h0)) begin
          n_fail++;
          $display("FAIL fetch_addr c%0d: got %h expected %h", k, mem_addr, en_x ? 32'h0040_0000 : 32'h0);
        end
      end
      if (if_done) if_req = 1'b0;
    end
    if_req = 1'b0;
    n_checks++;
    if (if_rdata !== 32'h2008_0005) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h expected 20080005", if_rdata);
    end
  endtask

  task automatic test_store();
    logic [DW-1:0] d_before;
    logic          en_x;
    int            cyc;
    d_before = exp_d_rdata;
    @(negedge clk);
    d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1;
    push(1'b1, 1'b1, d_addr, d_wdata);
    for (int k = 1; k <= WAIT_CYC + 2; k++) begin
      @(negedge clk);
      en_x = (k <= WAIT_CYC);
      n_checks++;
      if ({mem_en, mem_we, d_done, d_rdata} !== {en_x, en_x, (k == WAIT_CYC + 1), d_before}) begin
        n_fail++;
        $display("FAIL store_ctrl c%0d: got en=%b we=%b done=%b rdata=%h, expected %b %b %b %h",
                 k, mem_en, mem_we, d_done, d_rdata, en_x, en_x, (k == WAIT_CYC + 1), d_before);
      end
      if (k != WAIT_CYC + 1) begin
        n_checks++;
        if ({mem_addr, mem_wdata} !== (en_x ? {32'h1001_0000, 32'hDEAD_BEEF} : 64'h0)) begin
          n_fail++;
          $display("FAIL store_bus c%0d: got addr=%h wdata=%h", k, mem_addr, mem_wdata);
        end
      end
      if (d_done) begin d_req = 1'b0; d_we = 1'b0; end
    end
    d_req = 1'b0; d_we = 1'b0;
    // Read the stored word back through the load path.
    @(negedge clk);
    d_req = 1'b1;
    push(1'b1, 1'b0, d_addr, '0);
    wait_done(1'b1, 4 * WAIT_CYC + 6, cyc);
    d_req = 1'b0;
    n_checks++;
    if (cyc != WAIT_CYC + 1 || d_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_readback: got latency %0d rdata %h, expected %0d DEADBEEF", cyc, d_rdata, WAIT_CYC + 1);
    end
  endtask

  task automatic test_tie();
    bit   exp_d [3];
    bit   got_d, served_d, seen;
    logic got_owner;
    int   cyc;
`ifdef ARB_RR_EN
    exp_d = '{1'b1, 1'b0, 1'b1};
`else
    exp_d = '{1'b1, 1'b1, 1'b1};
`endif
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    if_addr = 32'h0040_0200; d_addr = 32'h1001_0100; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int r = 0; r < 3; r++) begin
      push(exp_d[r], 1'b0, exp_d[r] ? d_addr : if_addr, exp_d[r] ? d_wdata : '0);
      cyc = -1; got_d = 1'b0; seen = 1'b0; got_owner = 1'bx;
      for (int i = 1; i <= 2 * WAIT_CYC + 6; i++) begin
        @(negedge clk);
        if (mem_en && !seen) begin got_owner = owner; seen = 1'b1; end
        if (if_done || d_done) begin got_d = d_done; cyc = i; break; end
      end
      n_checks++;
      if (cyc < 0 || got_d != exp_d[r] || got_owner !== exp_d[r]) begin
        n_fail++;
        $display("FAIL tie_round%0d: got done_d=%b owner=%b latency=%0d, expected grant %s",
                 r, got_d, got_owner, cyc, exp_d[r] ? "data" : "fetch");
      end
      served_d = (cyc < 0) ? exp_d[r] : got_d;
      if (served_d) d_req = 1'b0; else if_req = 1'b0;
      @(negedge clk);
      if (r < 2) begin
        if (served_d) begin d_addr = d_addr + 32'd4; d_req = 1'b1; end
        else begin if_addr = if_addr + 32'd4; if_req = 1'b1; end
      end
    end
    // The remaining fetch is now the only requester.
    push(1'b0, 1'b0, if_addr, '0);
    wait_done(1'b0, 4 * WAIT_CYC + 6, cyc);
    if_req = 1'b0;
    n_checks++;
    if (cyc != WAIT_CYC + 1) begin
      n_fail++;
      $display("FAIL tie_fetch_tail: got latency %0d expected %0d", cyc, WAIT_CYC + 1);
    end
  endtask

  task automatic test_wait_busy();
    int cyc;
    @(negedge clk);
    d_addr = 32'h1001_0200; d_we = 1'b0; d_req = 1'b1;
    push(1'b1, 1'b0, d_addr, '0);
    @(negedge clk);
    if_addr = 32'h0040_0100; if_req = 1'b1;
    push(1'b0, 1'b0, if_addr, '0);
    wait_done(1'b1, 4 * WAIT_CYC + 6, cyc);
    d_req = 1'b0;
    n_checks++;
    if (cyc != WAIT_CYC) begin
      n_fail++;
      $display("FAIL busy_d_done: got %0d expected %0d", cyc, WAIT_CYC);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, mem_en, mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL busy_idle_gap: got busy=%b en=%b addr=%h, expected 0 0 0", busy, mem_en, mem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({busy, owner, mem_en, mem_addr} !== {1'b1, 1'b0, 1'b1, 32'h0040_0100}) begin
      n_fail++;
      $display("FAIL busy_fetch_grant: got busy=%b owner=%b en=%b addr=%h, expected 1 0 1 00400100",
               busy, owner, mem_en, mem_addr);
    end
    wait_done(1'b0, 4 * WAIT_CYC + 6, cyc);
    if_req = 1'b0;
    n_checks++;
    if (cyc != WAIT_CYC) begin
      n_fail++;
      $display("FAIL busy_if_done: got %0d expected %0d", cyc, WAIT_CYC);
    end
  endtask

  task automatic test_reset_mid();
    bit saw;
    mem[32'h1001_0300] = 32'hCAFE_F00D;
    @(negedge clk);
    d_addr = 32'h1001_0300; d_we = 1'b0; d_req = 1'b1;
    push(1'b1, 1'b0, d_addr, '0);
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_started: got mem_en=%b expected 1", mem_en);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_en, busy, d_done, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_cleared: got en=%b busy=%b done=%b rdata=%h, expected all 0",
               mem_en, busy, d_done, d_rdata);
    end
    reset = 1'b0; d_req = 1'b0;
    saw = 1'b0;
    repeat (WAIT_CYC + 4) begin
      @(negedge clk);
      if (d_done || mem_en) saw = 1'b1;
    end
    n_checks++;
    if (saw || d_rdata !== '0) begin
      n_fail++;
      $display("FAIL rstmid_abandoned: got activity=%b d_rdata=%h, expected 0 00000000", saw, d_rdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_wait_busy();
    test_reset_mid();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d outstanding expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
